// File: rtl/bitsim_enc_pkg.sv
// Shared types and defaults for the bit-serial encoder blocks.
package bitsim_enc_pkg;

    typedef enum logic {SER_IDLE = 1'b0, SER_BUSY = 1'b1} ser_state_t;

    localparam int MASK_W_DEFAULT = 32;

endpackage

// File: rtl/priority_encoder_msb.sv
// MSB-first priority encoder: index i names bit [WIDTH-1-i], the highest set bit wins.
module priority_encoder_msb
    import bitsim_enc_pkg::*;
#(
    parameter int WIDTH = MASK_W_DEFAULT,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one_hot
);

    // Scan LSB to MSB so the highest set bit is the last one to claim idx.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int b = 0; b < WIDTH; b++) begin
            idx = in[b] ? IDX_W'(WIDTH - 1 - b) : idx;
        end
    end

    // A value is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
    always_comb begin
        any     = |in;
        one_hot = any && ((in & (in - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/bitmask_index_serializer.sv
// Streams the MSB-first index of every set bit of a mask, one per beat.
// BITMASK_SERIALIZER_ZERO_SKIP_EN: consume all-zero masks without emitting a beat.
module bitmask_index_serializer
    import bitsim_enc_pkg::*;
#(
    parameter int WIDTH = MASK_W_DEFAULT,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_mask,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_last,
    output logic             out_zero
);

    ser_state_t       state_r;
    ser_state_t       state_next_s;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_next_s;
    logic [WIDTH-1:0] clr_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic [IDX_W-1:0] bit_pos_s;
    logic             enc_any_s;
    logic             enc_one_hot_s;
    logic             busy_s;
    logic             fire_s;
    logic             load_s;
    logic             in_zero_s;
    logic             last_s;

`ifndef BITMASK_SERIALIZER_ZERO_SKIP_EN
    logic             zero_q;
    logic             zero_next_s;
`endif

    priority_encoder_msb #(
        .WIDTH   (WIDTH),
        .IDX_W   (IDX_W)
    ) u_penc (
        .in      (mask_q),
        .idx     (enc_idx_s),
        .any     (enc_any_s),
        .one_hot (enc_one_hot_s)
    );

    assign busy_s    = (state_r == SER_BUSY);
    assign in_zero_s = (in_mask == {WIDTH{1'b0}});

`ifdef BITMASK_SERIALIZER_ZERO_SKIP_EN
    assign last_s   = busy_s && enc_one_hot_s;
    assign out_zero = 1'b0;
`else
    assign last_s   = busy_s && (enc_one_hot_s || zero_q);
    assign out_zero = busy_s && zero_q;
`endif

    assign out_val  = busy_s;
    assign out_idx  = enc_any_s ? enc_idx_s : {IDX_W{1'b0}};
    assign out_last = last_s;
    assign in_rdy   = !busy_s || (out_rdy && last_s);
    assign fire_s   = busy_s && out_rdy;
    assign load_s   = in_val && in_rdy;

    // WIDTH is a power of two, so bit position WIDTH-1-idx is simply ~idx.
    assign bit_pos_s = ~out_idx;

    // One-hot select of the bit being emitted, used to retire it from mask_q.
    always_comb begin
        clr_s            = {WIDTH{1'b0}};
        clr_s[bit_pos_s] = 1'b1;
    end

    // Next state: a load (idle or on the last beat) has priority over retiring a bit.
    always_comb begin
        state_next_s = state_r;
        mask_next_s  = mask_q;
`ifndef BITMASK_SERIALIZER_ZERO_SKIP_EN
        zero_next_s  = zero_q;
`endif
        if (load_s) begin
            mask_next_s  = in_mask;
`ifdef BITMASK_SERIALIZER_ZERO_SKIP_EN
            state_next_s = in_zero_s ? SER_IDLE : SER_BUSY;
`else
            state_next_s = SER_BUSY;
            zero_next_s  = in_zero_s;
`endif
        end else if (fire_s) begin
            if (last_s) begin
                state_next_s = SER_IDLE;
                mask_next_s  = {WIDTH{1'b0}};
`ifndef BITMASK_SERIALIZER_ZERO_SKIP_EN
                zero_next_s  = 1'b0;
`endif
            end else begin
                mask_next_s  = mask_q & ~clr_s;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State registers; reset discards any in-flight mask immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= SER_IDLE;
            mask_q  <= {WIDTH{1'b0}};
`ifndef BITMASK_SERIALIZER_ZERO_SKIP_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            mask_q  <= mask_next_s;
`ifndef BITMASK_SERIALIZER_ZERO_SKIP_EN
            zero_q  <= zero_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_bitmask_index_serializer.sv
// Directed bench for bitmask_index_serializer with a decoder round-trip sweep.
module tb_bitmask_index_serializer;

    logic        clk;
    logic        reset;
    logic [31:0] in_mask;
    logic        in_val;
    logic        in_rdy;
    logic [4:0]  out_idx;
    logic        out_val;
    logic        out_rdy;
    logic        out_last;
    logic        out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    bitmask_index_serializer #(.WIDTH(32), .IDX_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_mask  (in_mask),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_idx  (out_idx),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one mask, collect its beats through a decoder model.
    task automatic run_mask(input logic [31:0] m, output logic [31:0] acc,
                            output int beats, output logic order_ok, output logic done);
        int prev;
        logic last;
        acc      = 32'h0;
        beats    = 0;
        order_ok = 1'b1;
        done     = 1'b0;
        prev     = -1;
        in_mask  = m;
        in_val   = 1'b1;
        tick();
        in_val   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            last = 1'b0;
            if (out_val) begin
                acc = acc | (32'h8000_0000 >> out_idx);
                if (int'(out_idx) <= prev) order_ok = 1'b0;
                prev  = int'(out_idx);
                beats++;
                last  = out_last;
            end
            tick();
            if (last) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc;
        logic [31:0] m;
        int          beats;
        logic        order_ok;
        logic        done;

        reset   = 1'b1;
        in_mask = 32'h0;
        in_val  = 1'b0;
        out_rdy = 1'b1;
        #1;
        check_val("rst_out_val", 32'(out_val), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("rst_out_val_post", 32'(out_val), 32'd0);
        check_val("rst_in_rdy", 32'(in_rdy), 32'd1);
        check_val("rst_out_idx", 32'(out_idx), 32'd0);
        check_val("rst_out_last", 32'(out_last), 32'd0);
        check_val("rst_out_zero", 32'(out_zero), 32'd0);

        // Two-bit mask: MSB then LSB.
        in_mask = 32'h8000_0001;
        in_val  = 1'b1;
        #1;
        check_val("t1_in_rdy_idle", 32'(in_rdy), 32'd1);
        tick();
        in_val = 1'b0;
        #1;
        check_val("t1_b0_val", 32'(out_val), 32'd1);
        check_val("t1_b0_idx", 32'(out_idx), 32'd0);
        check_val("t1_b0_last", 32'(out_last), 32'd0);
        check_val("t1_b0_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        check_val("t1_b1_idx", 32'(out_idx), 32'd31);
        check_val("t1_b1_last", 32'(out_last), 32'd1);
        check_val("t1_b1_in_rdy", 32'(in_rdy), 32'd1);
        tick();
        check_val("t1_done_val", 32'(out_val), 32'd0);

        // Full mask with a stall before every beat.
        in_mask = 32'hFFFF_FFFF;
        in_val  = 1'b1;
        tick();
        in_val  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            out_rdy = 1'b0;
            #1;
            check_val("t2_idx", 32'(out_idx), 32'(i));
            check_val("t2_last", 32'(out_last), (i == 31) ? 32'd1 : 32'd0);
            tick();
            check_val("t2_idx_held", 32'(out_idx), 32'(i));
            check_val("t2_val_held", 32'(out_val), 32'd1);
            out_rdy = 1'b1;
            tick();
        end
        check_val("t2_done_val", 32'(out_val), 32'd0);

        // Back-to-back single-bit masks with in_val held.
        in_mask = 32'h0000_0004;
        in_val  = 1'b1;
        tick();
        in_mask = 32'h4000_0000;
        #1;
        check_val("t3_a_idx", 32'(out_idx), 32'd29);
        check_val("t3_a_last", 32'(out_last), 32'd1);
        check_val("t3_a_in_rdy", 32'(in_rdy), 32'd1);
        tick();
        in_val = 1'b0;
        #1;
        check_val("t3_b_val", 32'(out_val), 32'd1);
        check_val("t3_b_idx", 32'(out_idx), 32'd1);
        check_val("t3_b_last", 32'(out_last), 32'd1);
        tick();
        check_val("t3_done_val", 32'(out_val), 32'd0);

        // All-zero mask.
        in_mask = 32'h0;
        in_val  = 1'b1;
        tick();
        in_val  = 1'b0;
        #1;
`ifdef BITMASK_SERIALIZER_ZERO_SKIP_EN
        check_val("t4_skip_val", 32'(out_val), 32'd0);
        check_val("t4_skip_in_rdy", 32'(in_rdy), 32'd1);
        check_val("t4_skip_zero", 32'(out_zero), 32'd0);
`else
        check_val("t4_val", 32'(out_val), 32'd1);
        check_val("t4_idx", 32'(out_idx), 32'd0);
        check_val("t4_zero", 32'(out_zero), 32'd1);
        check_val("t4_last", 32'(out_last), 32'd1);
        tick();
        check_val("t4_done_val", 32'(out_val), 32'd0);
        check_val("t4_done_zero", 32'(out_zero), 32'd0);
`endif

        // Reset in the middle of a stream.
        in_mask = 32'h0F00_0000;
        in_val  = 1'b1;
        tick();
        in_val  = 1'b0;
        #1;
        check_val("t5_b0_idx", 32'(out_idx), 32'd4);
        tick();
        check_val("t5_b1_idx", 32'(out_idx), 32'd5);
        tick();
        reset = 1'b1;
        #1;
        check_val("t5_rst_val", 32'(out_val), 32'd0);
        check_val("t5_rst_idx", 32'(out_idx), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_val("t5_post_val", 32'(out_val), 32'd0);
        check_val("t5_post_in_rdy", 32'(in_rdy), 32'd1);
        in_mask = 32'h0000_0001;
        in_val  = 1'b1;
        tick();
        in_val  = 1'b0;
        #1;
        check_val("t5_new_idx", 32'(out_idx), 32'd31);
        check_val("t5_new_last", 32'(out_last), 32'd1);
        tick();
        check_val("t5_new_done", 32'(out_val), 32'd0);

        // Decoder round trip over random sparse masks.
        for (int it = 0; it < 1000; it++) begin
            m = $urandom() & $urandom();
            if (m == 32'h0) m = 32'h0000_0100;
            run_mask(m, acc, beats, order_ok, done);
            check_val("rt_done", 32'(done), 32'd1);
            check_val("rt_or", acc, m);
            check_val("rt_beats", 32'(beats), 32'($countones(m)));
            check_val("rt_order", 32'(order_ok), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
